au_lead_det_pipe: RTL

- Pipelined, flow-controlled leading-bit detector for the arithmetic-unit library; successor to the combinational leading-zero detector.
- Searches from the MSB for the first '0' (MODE 0) or first '1' (MODE 1); the mode is selectable per transaction.
- Returns the one-hot position, the encoded leading-run count and a no-detect flag.
- Feeds normaliser and float-pack datapaths through a valid/ready stream interface with full backpressure.

---
 rtl/au_lead_det_pipe.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/au_lead_det_pipe.sv
// rtl/au_lead_det_pipe.sv - pipelined valid/ready leading-bit detector
//
// Searches a word from the MSB for the first '0' (in_mode=0) or the first
// '1' (in_mode=1) and returns the one-hot position, the count of bits above
// it and a no-detect flag. One or two register stages, full backpressure.
//
// Parameters:
//   WIDTH    input word length (>= 2)
//   LATENCY  1: prefix, decode and encode feed one output register
//            2: stage 1 holds prefix result + mode-adjusted word,
//               stage 2 holds decoded position and count
//   CW       count width, fixed at $clog2(WIDTH+1)
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid / in_ready    input handshake
//   in_a, in_mode          word to search, search polarity (travels with word)
//   out_valid / out_ready  output handshake
//   out_z                  one-hot position of detected bit, 0 if none
//   out_cnt                WIDTH-1-index of detected bit, WIDTH if none
//   out_no_det             1 when no target bit is present
module au_lead_det_pipe #(
    parameter  int WIDTH   = 8,
    parameter  int LATENCY = 1,
    localparam int CW      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic [CW-1:0]    out_cnt,
    output logic             out_no_det
);

    // p[i] = AND of b[WIDTH-1:i]; a running AND from the MSB down.
    function automatic logic [WIDTH-1:0] prefix_and(input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] p;
        p[WIDTH-1] = b[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            p[i] = p[i+1] & b[i];
        end
        return p;
    endfunction

    // The first zero of b below an all-ones prefix is the detected bit.
    function automatic logic [WIDTH-1:0] decode_z(input logic [WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] z;
        z[WIDTH-1] = ~b[WIDTH-1];
        for (int i = 0; i < WIDTH - 1; i++) begin
            z[i] = p[i+1] & ~b[i];
        end
        return z;
    endfunction

    // p is thermometer-shaped (set bits are contiguous from the MSB), so its
    // population count is the leading-ones run length, saturating at WIDTH.
    function automatic logic [CW-1:0] encode_cnt(input logic [WIDTH-1:0] p);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CW'(p[i]);
        end
        return cnt;
    endfunction

    // Holds in_ready low during reset and for the clock after release, so the
    // first accept happens on a clean edge.
    logic alive_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    logic             in_accept;
    logic [WIDTH-1:0] b_in;

    assign in_accept = in_valid & in_ready;
    assign b_in      = in_mode ? ~in_a : in_a;

    generate
        if (LATENCY == 1) begin : g_lat1

            logic             v0_q, v0_d;
            logic             adv0;
            logic [WIDTH-1:0] p_in;
            logic [WIDTH-1:0] z_q, z_d;
            logic [CW-1:0]    cnt_q, cnt_d;
            logic             nd_q, nd_d;

            assign adv0     = v0_q & out_ready;
            assign in_ready = alive_q & (~v0_q | adv0);

            always_comb begin
                p_in  = prefix_and(b_in);
                v0_d  = in_accept ? 1'b1 : (adv0 ? 1'b0 : v0_q);
                z_d   = z_q;
                cnt_d = cnt_q;
                nd_d  = nd_q;
                if (in_accept) begin
                    z_d   = decode_z(p_in, b_in);
                    cnt_d = encode_cnt(p_in);
                    nd_d  = p_in[0];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v0_q  <= 1'b0;
                    z_q   <= '0;
                    cnt_q <= '0;
                    nd_q  <= 1'b0;
                end else begin
                    v0_q  <= v0_d;
                    z_q   <= z_d;
                    cnt_q <= cnt_d;
                    nd_q  <= nd_d;
                end
            end

            assign out_valid  = v0_q;
            assign out_z      = z_q;
            assign out_cnt    = cnt_q;
            assign out_no_det = nd_q;

        end else begin : g_lat2

            // Stage 1: prefix result and mode-adjusted word.
            logic             v0_q, v0_d;
            logic [WIDTH-1:0] p0_q, p0_d;
            logic [WIDTH-1:0] b0_q, b0_d;
            // Stage 2: decoded position, count and no-detect flag.
            logic             v1_q, v1_d;
            logic [WIDTH-1:0] z_q, z_d;
            logic [CW-1:0]    cnt_q, cnt_d;
            logic             nd_q, nd_d;
            logic             adv0, adv1;

            assign adv1     = v1_q & out_ready;
            // Stage 1 moves into an empty stage 2 even while the output is
            // stalled, so bubbles collapse.
            assign adv0     = v0_q & (~v1_q | adv1);
            assign in_ready = alive_q & (~v0_q | adv0);

            always_comb begin
                v0_d  = in_accept ? 1'b1 : (adv0 ? 1'b0 : v0_q);
                v1_d  = adv0 ? 1'b1 : (adv1 ? 1'b0 : v1_q);
                p0_d  = p0_q;
                b0_d  = b0_q;
                z_d   = z_q;
                cnt_d = cnt_q;
                nd_d  = nd_q;
                if (in_accept) begin
                    p0_d = prefix_and(b_in);
                    b0_d = b_in;
                end
                if (adv0) begin
                    z_d   = decode_z(p0_q, b0_q);
                    cnt_d = encode_cnt(p0_q);
                    nd_d  = p0_q[0];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v0_q  <= 1'b0;
                    p0_q  <= '0;
                    b0_q  <= '0;
                    v1_q  <= 1'b0;
                    z_q   <= '0;
                    cnt_q <= '0;
                    nd_q  <= 1'b0;
                end else begin
                    v0_q  <= v0_d;
                    p0_q  <= p0_d;
                    b0_q  <= b0_d;
                    v1_q  <= v1_d;
                    z_q   <= z_d;
                    cnt_q <= cnt_d;
                    nd_q  <= nd_d;
                end
            end

            assign out_valid  = v1_q;
            assign out_z      = z_q;
            assign out_cnt    = cnt_q;
            assign out_no_det = nd_q;

        end
    endgenerate

endmodule
